// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the Hack CPU program counter: imem req/ack fetch, jump decode, halt detection.
// Optional feature: define SINGLE_STEP_EN to add the debug 'step' input and the PAUSE state.
module pc_sequencer #(
    parameter int DATA_SIZE = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
`ifdef SINGLE_STEP_EN
    input  logic                 step,
`endif
    input  logic [DATA_SIZE-1:0] pc_value,
    input  logic [DATA_SIZE-1:0] a_reg,
    input  logic                 alu_zr,
    input  logic                 alu_ng,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [DATA_SIZE-1:0] imem_rdata,
    output logic [DATA_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic                 pc_load,
    output logic                 pc_inc,
    output logic [DATA_SIZE-1:0] pc_in,
    output logic                 halted,
    output logic                 timeout_err
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          is_c_instr;
    logic          take;
    logic          self_loop;

    // Jump condition from the C-instruction jump bits against the ALU flags
    assign is_c_instr = instr[DATA_SIZE-1];
    assign take       = is_c_instr &
                        ((instr[2] & alu_ng) |
                         (instr[1] & alu_zr) |
                         (instr[0] & ~alu_ng & ~alu_zr));
    assign self_loop  = take & (a_reg == pc_value);

    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_EXEC);
    assign pc_load     = (state == S_EXEC) & take & ~self_loop;
    assign pc_inc      = (state == S_EXEC) & ~take;
    assign pc_in       = a_reg;
    assign halted      = (state == S_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            instr       <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    // An ack arriving on the expiry cycle still completes the fetch
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        timer <= '0;
                        state <= S_EXEC;
                    end else if ((TIMEOUT != 0) && (timer == TIMEOUT_VAL)) begin
                        timeout_err <= 1'b1;
                        state       <= S_HALT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_EXEC: begin
                    timer <= '0;
                    if (self_loop) begin
                        state <= S_HALT;
                    end else begin
`ifdef SINGLE_STEP_EN
                        state <= S_PAUSE;
`else
                        state <= run ? S_FETCH : S_IDLE;
`endif
                    end
                end
`ifdef SINGLE_STEP_EN
                S_PAUSE: begin
                    if (!run)      state <= S_IDLE;
                    else if (step) state <= S_FETCH;
                end
`endif
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
